// File: rtl/alarm_key_entry.sv
// Alarm-clock keypad entry: collects up to four BCD digits and issues a load
// strobe for alarm or current time. Latency: one cycle from key_valid to outputs.
// Optional build macro ALARM_KEY_TIMEOUT_EN adds a one_second inactivity timeout.
module alarm_key_entry #(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       key_valid,
  output logic [3:0] key_ms_hr,
  output logic [3:0] key_ls_hr,
  output logic [3:0] key_ms_min,
  output logic [3:0] key_ls_min,
  output logic       show_new_time,
  output logic       show_a,
  output logic       load_new_a,
  output logic       load_new_c
);

  localparam logic [3:0] KEY_ALARM = 4'd10;
  localparam logic [3:0] KEY_TIME  = 4'd11;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    SHOW_ALARM,
    LOAD_ALARM,
    LOAD_TIME
  } state_t;

  state_t      state_q, state_d;
  // Buffer packed as {ms_hr, ls_hr, ms_min, ls_min}; a digit enters at the low nibble.
  logic [15:0] buf_q, buf_d;

  logic key_digit;
  logic key_alarm;
  logic key_time;

  assign key_digit = key_valid && (key <= 4'd9);
  assign key_alarm = key_valid && (key == KEY_ALARM);
  assign key_time  = key_valid && (key == KEY_TIME);

`ifdef ALARM_KEY_TIMEOUT_EN
  logic [3:0] cnt_q, cnt_d;
  logic       timeout_hit;

  // Timeout fires only on a pulse with no key activity in the same cycle.
  assign timeout_hit = one_second && !key_valid && (cnt_q == 4'(TIMEOUT_SEC - 1));

  // Inactivity counter: restarts on entry and on each accepted digit; any key
  // arriving together with a pulse also restarts it instead of counting.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && key_digit) begin
      cnt_d = 4'd0;
    end else if (state_q == ENTRY) begin
      if (key_digit || (key_valid && one_second) || timeout_hit) begin
        cnt_d = 4'd0;
      end else if (one_second) begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end
`else
  // The pulse has no function without the timeout feature.
  logic unused_one_second;
  assign unused_one_second = one_second;
`endif

  // Next state and buffer from the current state and the qualified key.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (key_digit) begin
          buf_d   = {buf_q[11:0], key};
          state_d = ENTRY;
        end else if (key_alarm) begin
          state_d = SHOW_ALARM;
        end
      end
      ENTRY: begin
        if (key_digit) begin
          buf_d = {buf_q[11:0], key};
        end else if (key_alarm) begin
          state_d = LOAD_ALARM;
        end else if (key_time) begin
          state_d = LOAD_TIME;
        end
`ifdef ALARM_KEY_TIMEOUT_EN
        else if (timeout_hit) begin
          buf_d   = 16'd0;
          state_d = IDLE;
        end
`endif
      end
      SHOW_ALARM: begin
        // Any key just dismisses the alarm display; it is not shifted in.
        if (key_valid) begin
          state_d = IDLE;
        end
      end
      LOAD_ALARM, LOAD_TIME: begin
        // Strobe cycle: keys are dropped, buffer is cleared on the way out.
        buf_d   = 16'd0;
        state_d = IDLE;
      end
      default: begin
        buf_d   = 16'd0;
        state_d = IDLE;
      end
    endcase
  end

  // State, buffer and registered output decode of the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      buf_q         <= 16'd0;
      show_new_time <= 1'b0;
      show_a        <= 1'b0;
      load_new_a    <= 1'b0;
      load_new_c    <= 1'b0;
`ifdef ALARM_KEY_TIMEOUT_EN
      cnt_q         <= 4'd0;
`endif
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      show_new_time <= (state_d == ENTRY);
      show_a        <= (state_d == SHOW_ALARM);
      load_new_a    <= (state_d == LOAD_ALARM);
      load_new_c    <= (state_d == LOAD_TIME);
`ifdef ALARM_KEY_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign key_ms_hr  = buf_q[15:12];
  assign key_ls_hr  = buf_q[11:8];
  assign key_ms_min = buf_q[7:4];
  assign key_ls_min = buf_q[3:0];

endmodule

// File: tb/tb_alarm_key_entry.sv
// Bench for alarm_key_entry: directed scenarios pinned with literal values,
// then randomized keys, pulses and asynchronous resets, all checked every cycle
// against a small behavioural model of the keypad entry rules.
module tb_alarm_key_entry;

  localparam int TO = 10;

  logic       clock = 1'b0;
  logic       reset;
  logic       one_second;
  logic [3:0] key;
  logic       key_valid;
  logic [3:0] key_ms_hr, key_ls_hr, key_ms_min, key_ls_min;
  logic       show_new_time, show_a, load_new_a, load_new_c;

  always #5 clock = ~clock;

  alarm_key_entry #(.TIMEOUT_SEC(TO)) dut (
    .clock        (clock),
    .reset        (reset),
    .one_second   (one_second),
    .key          (key),
    .key_valid    (key_valid),
    .key_ms_hr    (key_ms_hr),
    .key_ls_hr    (key_ls_hr),
    .key_ms_min   (key_ms_min),
    .key_ls_min   (key_ls_min),
    .show_new_time(show_new_time),
    .show_a       (show_a),
    .load_new_a   (load_new_a),
    .load_new_c   (load_new_c)
  );

  wire [15:0] dut_buf = {key_ms_hr, key_ls_hr, key_ms_min, key_ls_min};

  int checks = 0;
  int errors = 0;

  // Behavioural model: what the user has typed and what the display is doing.
  int  m_digits;      // entered value as a 4-nibble number
  bit  m_entering;    // user is typing a time
  bit  m_alarm_shown; // alarm time on display
  bit  m_strobe_a;    // alarm load pending this cycle
  bit  m_strobe_c;    // time load pending this cycle
  int  m_idle_secs;   // seconds without a key while typing

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_digits = 0;
    m_entering = 0;
    m_alarm_shown = 0;
    m_strobe_a = 0;
    m_strobe_c = 0;
    m_idle_secs = 0;
  endtask

  task automatic model_step(input bit kv, input int k, input bit os);
    if (m_strobe_a || m_strobe_c) begin
      m_strobe_a = 0;
      m_strobe_c = 0;
      m_digits = 0;
    end else if (m_alarm_shown) begin
      if (kv) m_alarm_shown = 0;
    end else if (m_entering) begin
      if (kv && k < 10) begin
        m_digits = (m_digits * 16 + k) % 65536;
        m_idle_secs = 0;
      end else if (kv && k == 10) begin
        m_entering = 0;
        m_strobe_a = 1;
      end else if (kv && k == 11) begin
        m_entering = 0;
        m_strobe_c = 1;
      end
`ifdef ALARM_KEY_TIMEOUT_EN
      else if (os) begin
        if (kv) m_idle_secs = 0;
        else if (m_idle_secs == TO - 1) begin
          m_entering = 0;
          m_digits = 0;
          m_idle_secs = 0;
        end else m_idle_secs++;
      end
`endif
    end else if (kv) begin
      if (k < 10) begin
        m_digits = (m_digits * 16 + k) % 65536;
        m_entering = 1;
        m_idle_secs = 0;
      end else if (k == 10) begin
        m_alarm_shown = 1;
      end
    end
  endtask

  // Per-cycle comparison of every output against the model.
  task automatic compare();
    chk("buffer", dut_buf, 16'(m_digits));
    chk("show_new_time", 16'(show_new_time), 16'(m_entering));
    chk("show_a", 16'(show_a), 16'(m_alarm_shown));
    chk("load_new_a", 16'(load_new_a), 16'(m_strobe_a));
    chk("load_new_c", 16'(load_new_c), 16'(m_strobe_c));
    chk("onehot", 16'(show_new_time + show_a + load_new_a + load_new_c <= 1), 16'd1);
  endtask

  // One clock: drive at the falling edge, let the DUT sample, check at the next fall.
  task automatic cyc(input bit kv, input int k, input bit os);
    key_valid = kv;
    key = 4'(k);
    one_second = os;
    @(posedge clock);
    model_step(kv, k, os);
    @(negedge clock);
    compare();
  endtask

  // Reset raised between edges; outputs must clear before any clock edge.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_buffer", dut_buf, 16'h0000);
    chk("rst_flags", {12'd0, show_new_time, show_a, load_new_a, load_new_c}, 16'h0000);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    key_valid = 1'b0;
    key = 4'd0;
    one_second = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    chk("reset_buffer", dut_buf, 16'h0000);
    chk("reset_flags", {12'd0, show_new_time, show_a, load_new_a, load_new_c}, 16'h0000);
    reset = 1'b0;
    cyc(0, 0, 0);

    // 1,2,3,0 then TIME
    cyc(1, 1, 0);
    chk("lit_snt_first", 16'(show_new_time), 16'd1);
    cyc(1, 2, 0);
    cyc(1, 3, 0);
    cyc(1, 0, 0);
    chk("lit_buf_1230", dut_buf, 16'h1230);
    cyc(1, 11, 0);
    chk("lit_load_c", {load_new_c, load_new_a, dut_buf[13:0]}, 16'h9230);
    cyc(0, 0, 0);
    chk("lit_after_c", {show_new_time, load_new_c, dut_buf[13:0]}, 16'h0000);

    // 0,6,4,5,3 then ALARM
    cyc(1, 0, 0); cyc(1, 6, 0); cyc(1, 4, 0); cyc(1, 5, 0); cyc(1, 3, 0);
    cyc(1, 10, 0);
    chk("lit_buf_6453", dut_buf, 16'h6453);
    chk("lit_load_a", {15'd0, load_new_a}, 16'd1);
    cyc(0, 0, 0);
    chk("lit_after_a", dut_buf, 16'h0000);

    // ALARM display then dismissal by a digit
    cyc(1, 10, 0);
    chk("lit_show_a", 16'(show_a), 16'd1);
    cyc(1, 7, 0);
    chk("lit_dismiss", {show_a, show_new_time, dut_buf[13:0]}, 16'h0000);

    // Unused code 13 in each state, and a key during the time load
    cyc(1, 13, 0);
    chk("lit_idle_13", {show_a, show_new_time, dut_buf[13:0]}, 16'h0000);
    cyc(1, 9, 0); cyc(1, 8, 0); cyc(1, 13, 0);
    chk("lit_entry_13", dut_buf, 16'h0098);
    cyc(1, 11, 0);
    cyc(1, 5, 0);
    chk("lit_key_in_load", {load_new_c, show_new_time, dut_buf[13:0]}, 16'h0000);
    cyc(1, 10, 0); cyc(1, 13, 0);
    cyc(1, 4, 0); cyc(1, 10, 0); cyc(1, 13, 0); cyc(0, 0, 0);

    // Pulses while typing (timeout only when the feature is built in)
    cyc(1, 5, 0);
    for (int i = 0; i < TO + 2; i++) cyc(0, 0, 1);
    cyc(1, 11, 0); cyc(0, 0, 0);

    // Asynchronous reset mid-entry and during a load strobe
    cyc(1, 1, 0); cyc(1, 2, 0); cyc(1, 3, 0); cyc(1, 4, 0);
    chk("lit_buf_1234", dut_buf, 16'h1234);
    async_reset();
    repeat (3) cyc(0, 0, 0);
    cyc(1, 8, 0); cyc(1, 10, 0);
    async_reset();
    repeat (3) cyc(0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) async_reset();
      else cyc($urandom_range(0, 2) == 0, int'($urandom_range(0, 15)),
               $urandom_range(0, 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alarm_key_entry.md
ALARM_KEY_ENTRY -- requirements
Module: alarm_key_entry

Interface
REQ-001 SHALL have parameter TIMEOUT_SEC, default 10, meaning one_second pulses of keypad inactivity before an abandoned entry is discarded (range 2..15).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port one_second  input  1  single-cycle pulse once per second, synchronous to clock.
REQ-005 SHALL have port key  input  4  key code: 0-9 digit, 10 ALARM, 11 TIME, 12-15 unused.
REQ-006 SHALL have port key_valid  input  1  single-cycle strobe qualifying key.
REQ-007 SHALL have ports key_ms_hr, key_ls_hr, key_ms_min, key_ls_min  output  4 each  entered digit buffer, BCD.
REQ-008 SHALL have port show_new_time  output  1  high while entry in progress (display shows buffer).
REQ-009 SHALL have port show_a  output  1  high while alarm time is being displayed.
REQ-010 SHALL have port load_new_a  output  1  one-cycle strobe: load buffer as alarm time.
REQ-011 SHALL have port load_new_c  output  1  one-cycle strobe: load buffer as current time.

Function
REQ-012 SHALL implement a Moore FSM with states IDLE, ENTRY, SHOW_ALARM, LOAD_ALARM, LOAD_TIME; all outputs registered, decoded from state/buffer only.
REQ-013 SHALL, in IDLE, on key_valid with digit: shift digit into buffer, go ENTRY; with ALARM: go SHOW_ALARM; with TIME or unused code: stay IDLE, buffer unchanged.
REQ-014 SHALL shift a digit as: key_ms_hr<=key_ls_hr, key_ls_hr<=key_ms_min, key_ms_min<=key_ls_min, key_ls_min<=key (oldest digit discarded after four).
REQ-015 SHALL, in ENTRY, on digit: shift and stay; on ALARM: go LOAD_ALARM; on TIME: go LOAD_TIME; unused codes ignored.
REQ-016 SHALL, in SHOW_ALARM, hold show_a=1; the next key_valid of any code is consumed (no shift) and returns to IDLE.
REQ-017 SHALL assert load_new_a (LOAD_ALARM) or load_new_c (LOAD_TIME) for exactly one cycle with buffer still holding the entered value, then clear buffer to 0 and go IDLE next cycle.
REQ-018 SHALL ignore key_valid while in LOAD_ALARM or LOAD_TIME (key dropped, no shift).
REQ-019 SHALL drive show_new_time=1 only in ENTRY, show_a=1 only in SHOW_ALARM; at most one of show_new_time, show_a, load_new_a, load_new_c high in any cycle.
REQ-020 SHALL have latency one cycle: key_valid sampled at edge N, state/buffer/outputs change visible after edge N.
REQ-021 SHALL not range-check digits (e.g. ms_hr>2 accepted); validation belongs to the time counter.

Reset
REQ-022 SHALL, while reset high, force state IDLE, all four buffer digits 0, timeout counter 0, all 1-bit outputs 0, independent of clock.
REQ-023 SHALL, on reset asserted mid-entry or during a load strobe, abort without issuing or completing any load strobe.

Configuration
REQ-024 SHALL, with macro ALARM_KEY_TIMEOUT_EN defined, include a 4-bit inactivity counter cleared on entering ENTRY and on every digit accepted in ENTRY, incremented on one_second in ENTRY.
REQ-025 SHALL, with ALARM_KEY_TIMEOUT_EN defined, on one_second with counter==TIMEOUT_SEC-1 and no key_valid that cycle, clear buffer to 0 and go IDLE with no load strobe; key_valid in the same cycle as one_second takes priority and clears the counter.
REQ-026 SHALL, with ALARM_KEY_TIMEOUT_EN undefined, contain no counter, ignore one_second, and remain in ENTRY until ALARM, TIME or reset.

Verification
REQ-027 Digits 1,2,3,0 then TIME -> buffer 1,2,3,0, show_new_time high after first digit, load_new_c high one cycle, buffer 0 next cycle, state IDLE.
REQ-028 Digits 0,6,4,5,3 then ALARM -> buffer 6,4,5,3, load_new_a one cycle, load_new_c never high.
REQ-029 IDLE, ALARM key -> show_a=1; digit 7 -> show_a=0, buffer still 0, IDLE.
REQ-030 (ALARM_KEY_TIMEOUT_EN, TIMEOUT_SEC=10) digit 5 then 10 one_second pulses -> buffer 0, IDLE after 10th pulse; digit 5 coincident with 10th pulse -> remains ENTRY, counter 0.
REQ-031 Reset asserted asynchronously between clock edges during ENTRY with buffer 1,2,3,4 -> all outputs 0 immediately; no load strobe after release.
REQ-032 key_valid with code 13 in every state, and any key during LOAD_TIME -> no state or buffer change beyond normal LOAD_TIME exit.
